// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor sequencer.
package gcd_lcm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        COMMON,
        ODD_A,
        REDUCE,
        SCALE,
        DIV,
        MUL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_DIV,
        DM_MUL
    } dm_phase_t;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    // Enough bits to count 0..width and to hold the common power-of-two exponent.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_lcm_ctrl_if.sv
// Request/response bundle between the core (master) and the GCD/LCM sequencer (slave).
interface gcd_lcm_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/gcd_lcm_ctrl_seq_divmul.sv
// Shared shift/add/subtract engine: restoring divide a/g, then shift-add multiply q*b.
// Each phase takes WIDTH cycles; finished pulses once the full product is registered.
module gcd_lcm_ctrl_seq_divmul
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               mul_phase,
    output logic               finished,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    dm_phase_t          phase;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               fin;

    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   quo_next;
    logic               last;

    // The remainder after a successful subtract is below the divisor, so the low WIDTH bits suffice.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign fits     = (shifted >= {1'b0, dsr});
    assign rem_sub  = shifted[WIDTH-1:0] - dsr;
    assign quo_next = {quo[WIDTH-2:0], fits};
    assign last     = (cnt == CW'(WIDTH - 1));

    assign mul_phase = (phase == DM_MUL);
    assign finished  = fin;
    assign product   = acc;

    // Step the divide, hand the fresh quotient straight to the multiply, then flag completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= DM_IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dsr    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            fin    <= 1'b0;
        end else if (start) begin
            phase  <= DM_DIV;
            cnt    <= '0;
            quo    <= dividend;
            rem    <= '0;
            dsr    <= divisor;
            mplier <= multiplier;
            acc    <= '0;
            fin    <= 1'b0;
        end else begin
            case (phase)
                DM_DIV: begin
                    rem <= fits ? rem_sub : shifted[WIDTH-1:0];
                    quo <= quo_next;
                    if (last) begin
                        phase <= DM_MUL;
                        cnt   <= '0;
                        mcand <= {{WIDTH{1'b0}}, quo_next};
                        acc   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DM_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (last) begin
                        phase <= DM_IDLE;
                        fin   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    fin <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gcd_lcm_ctrl.sv
// GCD/LCM coprocessor sequencer: binary (Stein) GCD, then LCM as (a/gcd)*b.
// busy stalls the core from the cycle after start through the single-cycle done pulse.
module gcd_lcm_ctrl
    import gcd_lcm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    gcd_lcm_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state;
    logic               op_lat;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   b_lat;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [CW-1:0]      k;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               overflow_r;

    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   y_minus_x;
    logic               dm_start;
    logic               dm_mul_phase;
    logic               dm_finished;
    logic [2*WIDTH-1:0] dm_product;

    assign g         = x << k;
    assign y_minus_x = y - x;
    assign dm_start  = (state == SCALE) && (op_lat == OP_LCM);

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.overflow = overflow_r;

    gcd_lcm_ctrl_seq_divmul #(
        .WIDTH(WIDTH)
    ) u_seq_divmul (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (dm_start),
        .dividend  (a_lat),
        .divisor   (g),
        .multiplier(b_lat),
        .mul_phase (dm_mul_phase),
        .finished  (dm_finished),
        .product   (dm_product)
    );

    // Main sequencer: operand capture, Stein reduction, then hand-off to the divide/multiply engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_lat     <= OP_GCD;
            a_lat      <= '0;
            b_lat      <= '0;
            x          <= '0;
            y          <= '0;
            k          <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_lat  <= bus.a;
                        b_lat  <= bus.b;
                        op_lat <= bus.op;
                        x      <= bus.a;
                        y      <= bus.b;
                        k      <= '0;
                        busy_r <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if ((a_lat == '0) || (b_lat == '0)) begin
                        result_r   <= (op_lat == OP_GCD) ? (a_lat | b_lat) : '0;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= COMMON;
                    end
                end
                COMMON: begin
                    if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + 1'b1;
                    end else begin
                        state <= ODD_A;
                    end
                end
                ODD_A: begin
                    if (!x[0]) begin
                        x <= x >> 1;
                    end else begin
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (!y[0]) begin
                        y <= y >> 1;
                    end else if (x > y) begin
                        x <= y;
                        y <= x;
                    end else begin
                        y <= y_minus_x;
                        if (y_minus_x == '0) begin
                            state <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    if (op_lat == OP_GCD) begin
                        result_r   <= g;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (dm_mul_phase) begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (dm_finished) begin
                        result_r   <= dm_product[WIDTH-1:0];
                        overflow_r <= |dm_product[2*WIDTH-1:WIDTH];
                        done_r     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_ctrl.sv
// Scoreboard bench for gcd_lcm_ctrl: directed requests push expectations, a monitor checks each done.
module tb_gcd_lcm_ctrl;

    localparam int W       = 32;
    localparam int GCD_LAT = 6 * W + 8;
    localparam int LCM_LAT = GCD_LAT + 2 * W + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           startCyc;
        int           maxLat;
        bit           exact;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    gcd_lcm_ctrl_if #(.WIDTH(W)) bus();

    gcd_lcm_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure start-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input string name, input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] res, input logic ovf,
                                 input int maxLat, input bit exact);
        exp_t e;
        @(negedge clk);
        checkOutput({name, "_busy_before"}, bus.busy, 1'b0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.res = res; e.ovf = ovf; e.startCyc = cyc; e.maxLat = maxLat; e.exact = exact; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got no done want done within 400 cycles", name);
            sb.delete();
        end
        @(negedge clk);
        checkOutput({name, "_busy_after"}, bus.busy, 1'b0);
        checkOutput({name, "_done_after"}, bus.done, 1'b0);
    endtask

    // Monitor: every done must match the oldest pending expectation, within its latency bound.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious_done: got done=1 want no done");
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.startCyc;
                    checkOutput({e.name, "_result"}, bus.result, e.res);
                    checkOutput({e.name, "_overflow"}, bus.overflow, e.ovf);
                    if (e.exact) begin
                        checkOutput({e.name, "_latency"}, lat, e.maxLat);
                    end else begin
                        total++;
                        if (lat > e.maxLat) begin
                            bad++;
                            $display("[TB] FAIL %s_latency: got %0d want <= %0d", e.name, lat, e.maxLat);
                        end
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_done", bus.done, 1'b0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_overflow", bus.overflow, 1'b0);
        reset_n = 1'b1;

        applyStimulus("gcd_12_18", 1'b0, 32'd12, 32'd18, 32'd6, 1'b0, GCD_LAT, 1'b0);
        waitIdle("gcd_12_18");
        applyStimulus("lcm_4_6", 1'b1, 32'd4, 32'd6, 32'd12, 1'b0, LCM_LAT, 1'b0);
        waitIdle("lcm_4_6");

        // Starts while busy must be ignored.
        applyStimulus("lcm_21_6", 1'b1, 32'd21, 32'd6, 32'd42, 1'b0, LCM_LAT, 1'b0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd100; bus.b = 32'd75;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd9; bus.b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle("lcm_21_6");

        applyStimulus("gcd_0_7", 1'b0, 32'd0, 32'd7, 32'd7, 1'b0, 2, 1'b1);
        waitIdle("gcd_0_7");
        applyStimulus("gcd_0_0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2, 1'b1);
        waitIdle("gcd_0_0");
        applyStimulus("lcm_0_7", 1'b1, 32'd0, 32'd7, 32'd0, 1'b0, 2, 1'b1);
        waitIdle("lcm_0_7");

        applyStimulus("lcm_ovf", 1'b1, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b1, LCM_LAT, 1'b0);
        waitIdle("lcm_ovf");
        applyStimulus("gcd_msb", 1'b0, 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, GCD_LAT, 1'b0);
        waitIdle("gcd_msb");
        applyStimulus("lcm_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2, 1'b1, LCM_LAT, 1'b0);
        waitIdle("lcm_max");
        applyStimulus("lcm_8_12", 1'b1, 32'd8, 32'd12, 32'd24, 1'b0, LCM_LAT, 1'b0);
        waitIdle("lcm_8_12");

        // A start presented during the done cycle must also be ignored.
        applyStimulus("gcd_1071_462", 1'b0, 32'd1071, 32'd462, 32'd21, 1'b0, GCD_LAT, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checkOutput("gcd_1071_462_done_seen", seen, 1'b1);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd5; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("done_cycle_start_busy", bus.busy, 1'b0);
        checkOutput("done_cycle_start_result", bus.result, 32'd21);
        sb.delete();

        // Reset in the middle of REDUCE aborts without a done pulse.
        applyStimulus("gcd_48_180_abort", 1'b0, 32'd48, 32'd180, 32'd12, 1'b0, GCD_LAT, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("abort_busy_before_reset", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_done", bus.done, 1'b0);
        checkOutput("abort_result", bus.result, 32'd0);
        checkOutput("abort_overflow", bus.overflow, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus("gcd_48_180", 1'b0, 32'd48, 32'd180, 32'd12, 1'b0, GCD_LAT, 1'b0);
        waitIdle("gcd_48_180");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_ctrl.md
Name: gcd_lcm_ctrl

Overview:
- Multi-cycle sequencer for the GCD/LCM coprocessor attached to the RISC-V core.
- Accepts a start request with two unsigned operands and an op select. Computes GCD with binary (Stein) shift/subtract steps; computes LCM as (a / gcd) * b by sequential divide then multiply.
- Holds busy high so the core stalls, then pulses done with result valid.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 8..64.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  1  0 = GCD, 1 = LCM; sampled with start
- a  input  WIDTH  operand A, unsigned; sampled with start
- b  input  WIDTH  operand B, unsigned; sampled with start
- busy  output  1  high from the cycle after accepted start until the done cycle, inclusive
- done  output  1  one-cycle pulse; result/overflow valid
- result  output  WIDTH  GCD, or low WIDTH bits of LCM; held until the next accepted start
- overflow  output  1  LCM only: true product exceeded WIDTH bits; 0 for GCD

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, result=0, overflow=0; all internal registers cleared. Reset mid-operation aborts with no done pulse.
- IDLE + start=1: latch a, b, op; k=0; go CHECK. Any start while not IDLE is ignored, including in the DONE cycle.
- CHECK:
  - a=0 or b=0: result = (op=GCD ? a|b : 0), overflow=0, go DONE.
  - Otherwise go COMMON.
- COMMON: while x and y are both even, shift both right by 1 and increment k, one shift per cycle. Then go ODD_A.
- ODD_A: shift x right by 1 per cycle until x is odd, then go REDUCE.
- REDUCE, one action per cycle:
  - y even: y >>= 1.
  - Else if x > y: swap x and y.
  - Else: y = y - x. If the new y is 0, go SCALE.
- SCALE: g = x << k (one cycle).
  - GCD: result=g, go DONE.
  - LCM: go DIV.
- DIV: restoring shift-subtract, WIDTH cycles, q = a_latched / g. Remainder is always 0; not checked.
- MUL: shift-add, WIDTH cycles, 2*WIDTH-bit product p = q * b_latched. Then result = p[WIDTH-1:0], overflow = |p[2*WIDTH-1:WIDTH]. Go DONE.
- DONE: done=1 for exactly one cycle, busy=1 in the same cycle; next state IDLE.
- Latency bounds, from the start cycle to the done cycle:
  - Zero operand: exactly 2 cycles.
  - GCD: ≤ 6*WIDTH+8 cycles.
  - LCM: GCD cycles + 2*WIDTH + 1.
- Arithmetic is unsigned only. Subtract never underflows because REDUCE guarantees y ≥ x.

Decomposition:
- Package gcd_lcm_pkg holds:
  - state enum: IDLE, CHECK, COMMON, ODD_A, REDUCE, SCALE, DIV, MUL, DONE
  - op constants: OP_GCD=1'b0, OP_LCM=1'b1
  - counter width function: $clog2(WIDTH)+1
- One natural sub-module: seq_divmul. It is a shared shift/add/subtract engine running DIV then MUL with its own WIDTH-cycle counter and a start/finished handshake to the parent FSM.

Test Plan:
- GCD(12,18), WIDTH=32 -> one done pulse, result=6, overflow=0; busy low before start and after done.
- LCM(4,6) -> result=12, overflow=0. LCM(21,6) -> result=42.
- GCD(0,7) -> result=7; GCD(0,0) -> 0; LCM(0,7) -> 0. Each has done exactly 2 cycles after start.
- LCM(0x00010000,0x00010001) -> overflow=1, result=0x00010000 (true LCM 0x1_0001_0000). GCD(0x80000000,0x40000000) -> 0x40000000.
- Start pulses with different operands while busy, and in the DONE cycle -> ignored; first request's result unchanged; only one done.
- reset_n low mid-REDUCE of GCD(48,180) -> outputs 0 immediately, no done. Later GCD(48,180) -> 12 within the latency bound.
